remap: RTL and testbench
========================

Name: remap

Overview:
- Frame-buffer geometric remapper for 8-bit grayscale images (lens undistortion back end).
- The host first preloads one source frame through a byte write port.
- The host then issues one fixed-point source coordinate (map_x, map_y) per request.
- The block returns the bilinearly interpolated source pixel, or 0 when the coordinate falls outside the frame.

Parameters:
- IMAGE_WIDTH, 640, frame width in pixels.
- IMAGE_HEIGHT, 480, frame height in pixels.
- FRAC, 12, number of fractional bits in map_x/map_y.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_wr_en  in  1  write strobe for the frame RAM.
- mem_wr_addr  in  32  linear pixel address, row*IMAGE_WIDTH+col.
- mem_wr_data  in  8  pixel value to write.
- map_valid  in  1  coordinate request strobe.
- map_x  in  24  source x, two's-complement, FRAC fractional bits.
- map_y  in  24  source y, same format as map_x.
- map_ready  out  1  block idle and able to accept a request.
- out_valid  out  1  one-cycle result strobe.
- out_pixel  out  8  result pixel; held until the next result.

Behaviour:
- Reset: asynchronous. map_ready=0 while rst is high and 1 from the first clock after release. out_valid=0, out_pixel=0, FSM=IDLE. RAM contents are not reset.
- Frame RAM:
  - IMAGE_WIDTH*IMAGE_HEIGHT x 8 bits, one write port and one synchronous read port.
  - A write occurs when mem_wr_en=1 and mem_wr_addr < IMAGE_WIDTH*IMAGE_HEIGHT. Out-of-range writes are ignored.
  - Writes are accepted in any state.
  - A same-cycle read and write to the same address returns the old data (read-first).
- Handshake:
  - A request is accepted on a rising edge where map_valid=1 and map_ready=1.
  - map_x/map_y are captured on that edge and map_ready drops on the next cycle.
  - map_valid while busy is ignored and not queued.
- Coordinate split: ix = map_x >>> FRAC (signed), fx = map_x[FRAC-1:FRAC-8] as an 8-bit weight. iy and fy are derived the same way from map_y.
- Out of range: if ix<0, iy<0, ix>=IMAGE_WIDTH or iy>=IMAGE_HEIGHT, the result is 0. The RAM reads still run so latency stays constant.
- Neighbours:
  - x1 = min(ix+1, IMAGE_WIDTH-1) and y1 = min(iy+1, IMAGE_HEIGHT-1), i.e. edge clamp.
  - Read order is p00(iy,ix), p01(iy,x1), p10(y1,ix), p11(y1,x1), one address per cycle.
- Interpolation:
  - top = p00*(256-fx) + p01*fx (16 bits).
  - bot = p10*(256-fx) + p11*fx (16 bits).
  - acc = top*(256-fy) + bot*fy (24 bits).
  - out = (acc + 32768) >> 16, saturated to 255.
  - For integer coordinates (fx=fy=0) the result equals p00 exactly.
- FSM: IDLE -> RD00 -> RD01 -> RD10 -> RD11 -> WAIT (capture p11) -> CALC -> IDLE.
  - out_valid is pulsed on the cycle the FSM re-enters IDLE.
  - Fixed latency: out_valid is high exactly 7 cycles after the accepting edge.
  - map_ready is high again in that same cycle.
- out_pixel is registered when out_valid is set and stays stable afterwards until the next out_valid.
- Reset mid-request aborts the request; no out_valid is issued.

Decomposition:
- Package remap_pkg:
  - PIX_W=8, COORD_W=24, WEIGHT_W=8.
  - FSM state enum.
  - Function computing the linear address row*IMAGE_WIDTH+col.
- Sub-module remap_frame_ram: parameterised-depth, 8-bit, write port plus synchronous read port, read-first.
- The top-level remap holds the FSM, the coordinate split/clamp logic and the interpolator datapath.

Test Plan:
- Preload pixel[i] = i%256 over the full 640x480 frame. Request the integer coordinates (0,0), (159,119), (319,239), (479,359), (639,479), with map_x=ix<<12. Each out_pixel must equal pixel[iy*640+ix], e.g. (639,479) -> 255. out_valid must occur exactly 7 cycles after acceptance.
- Set p(10,10)=0, p(10,11)=200, p(11,10)=0, p(11,11)=200. Request x=10.5, y=10 -> 100. Request x=10.5, y=10.5 -> 100. Request x=10.25, y=10 -> 50.
- Out of range: map_x=-4096, map_x=640<<12, or map_y=480<<12 -> out_pixel=0 with normal latency.
- Edge clamp: request x=639.5, y=479.5 -> the output equals p(479,639).
- Handshake:
  - Pulse map_valid while busy -> no extra result.
  - Check that out_pixel holds its value for 10 idle cycles after out_valid.
  - Assert rst mid-request -> no out_valid; map_ready=1 after release, and the next request works.
- Issue a write to the address being read during a request -> the result uses the old value; a write to address 307200 is ignored.

Source files
------------

// File: rtl/remap_pkg.sv
// remap_pkg: shared widths, FSM state encoding and address helper for the
// frame-buffer remapper.
package remap_pkg;

  localparam int PIX_W    = 8;   // grayscale pixel width
  localparam int COORD_W  = 24;  // signed fixed-point coordinate width
  localparam int WEIGHT_W = 8;   // bilinear fractional weight width

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD00 = 3'd1,
    S_RD01 = 3'd2,
    S_RD10 = 3'd3,
    S_RD11 = 3'd4,
    S_WAIT = 3'd5,
    S_CALC = 3'd6
  } state_e;

  // Linear frame address of pixel (row, col) for a frame of the given width.
  function automatic logic [31:0] linear_addr(input logic [31:0] row,
                                              input logic [31:0] col,
                                              input logic [31:0] width);
    linear_addr = row * width + col;
  endfunction

endpackage

// File: rtl/remap_frame_ram.sv
// remap_frame_ram: DEPTH x 8-bit frame store, one write port and one
// synchronous read port. A read and a write to the same address in the same
// cycle return the old contents (read-first). Writes at or beyond DEPTH are
// dropped. Contents are deliberately not reset.
//   clk        in   clock
//   wr_en_i    in   write strobe
//   wr_addr_i  in   32-bit linear write address
//   wr_data_i  in   write data
//   rd_addr_i  in   read address (sampled every cycle)
//   rd_data_o  out  read data, one cycle after rd_addr_i
module remap_frame_ram
  import remap_pkg::*;
#(
  parameter int DEPTH = 307200,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [31:0]      wr_addr_i,
  input  logic [PIX_W-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [PIX_W-1:0] rd_data_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rd_data_q;
  logic             wr_ok_s;

  // The range check uses the full 32-bit address so that large addresses
  // cannot alias onto low locations after truncation.
  assign wr_ok_s = wr_en_i && (wr_addr_i < 32'(DEPTH));

  // Read-first storage: the read samples the array before the write lands.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr_i];
    if (wr_ok_s) begin
      mem_q[wr_addr_i[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/remap.sv
// remap: geometric remapper back end. The host preloads a frame through the
// byte write port, then issues one fixed-point source coordinate per request;
// the block returns the bilinearly interpolated pixel (0 when outside the
// frame) with a fixed latency.
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   mem_wr_en    in   frame RAM write strobe (accepted in any state)
//   mem_wr_addr  in   linear pixel address row*IMAGE_WIDTH+col
//   mem_wr_data  in   pixel value
//   map_valid    in   coordinate request strobe
//   map_x/map_y  in   signed source coordinate, FRAC fractional bits
//   map_ready    out  idle and able to accept a request
//   out_valid    out  one-cycle result strobe
//   out_pixel    out  result pixel, held until the next result
module remap
  import remap_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FRAC         = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_wr_en,
  input  logic [31:0]        mem_wr_addr,
  input  logic [PIX_W-1:0]   mem_wr_data,
  input  logic               map_valid,
  input  logic [COORD_W-1:0] map_x,
  input  logic [COORD_W-1:0] map_y,
  output logic               map_ready,
  output logic               out_valid,
  output logic [PIX_W-1:0]   out_pixel
);

  localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(IMAGE_WIDTH);
  localparam int RW    = $clog2(IMAGE_HEIGHT);
  localparam logic signed [COORD_W-1:0] W_S = COORD_W'(IMAGE_WIDTH);
  localparam logic signed [COORD_W-1:0] H_S = COORD_W'(IMAGE_HEIGHT);

  // ---------------------------------------------------------------- signals
  state_e                state_q, state_d;
  logic                  map_ready_q, map_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [PIX_W-1:0]      out_pixel_q, out_pixel_d;

  logic signed [COORD_W-1:0] ix_s, iy_s;
  logic                  oob_s;
  logic [CW-1:0]         col_s, col1_s;
  logic [RW-1:0]         row_s, row1_s;

  logic [CW-1:0]         col_q, col1_q;
  logic [RW-1:0]         row_q, row1_q;
  logic [WEIGHT_W-1:0]   fx_q, fy_q;
  logic                  oob_q;
  logic                  accept_s;

  logic [PIX_W-1:0]      p00_q, p01_q, p10_q, p11_q;
  logic [AW-1:0]         rd_addr_s;
  logic [PIX_W-1:0]      rd_data_s;

  logic [WEIGHT_W:0]     wx0_s, wy0_s;
  logic [16:0]           top_s, bot_s;
  logic [25:0]           acc_s, rnd_s;
  logic [9:0]            shr_s;
  logic [PIX_W-1:0]      interp_s;

  // ------------------------------------------------------------ frame RAM
  remap_frame_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (mem_wr_addr),
    .wr_data_i (mem_wr_data),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (rd_data_s)
  );

  // ---------------------------------------------------- coordinate split
  assign ix_s     = $signed(map_x) >>> FRAC;
  assign iy_s     = $signed(map_y) >>> FRAC;
  assign accept_s = map_valid && map_ready_q;

  // Range check and edge clamp. Out-of-range requests read pixel (0,0) so
  // the read sequence (and latency) is unchanged; the result is forced to 0.
  always_comb begin
    oob_s = ix_s[COORD_W-1] || iy_s[COORD_W-1] || (ix_s >= W_S) || (iy_s >= H_S);
    if (oob_s) begin
      col_s = '0;
      row_s = '0;
    end else begin
      col_s = ix_s[CW-1:0];
      row_s = iy_s[RW-1:0];
    end
    col1_s = (col_s == CW'(IMAGE_WIDTH - 1))  ? col_s : col_s + CW'(1);
    row1_s = (row_s == RW'(IMAGE_HEIGHT - 1)) ? row_s : row_s + RW'(1);
  end

  // Request capture: coordinates and weights latched on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      col1_q <= '0;
      row_q  <= '0;
      row1_q <= '0;
      fx_q   <= '0;
      fy_q   <= '0;
      oob_q  <= 1'b0;
    end else if (accept_s) begin
      col_q  <= col_s;
      col1_q <= col1_s;
      row_q  <= row_s;
      row1_q <= row1_s;
      fx_q   <= map_x[FRAC-1:FRAC-WEIGHT_W];
      fy_q   <= map_y[FRAC-1:FRAC-WEIGHT_W];
      oob_q  <= oob_s;
    end
  end

  // Read address: one neighbour per cycle, p00, p01, p10, p11.
  always_comb begin
    case (state_q)
      S_RD00:  rd_addr_s = AW'(linear_addr(32'(row_q),  32'(col_q),  32'(IMAGE_WIDTH)));
      S_RD01:  rd_addr_s = AW'(linear_addr(32'(row_q),  32'(col1_q), 32'(IMAGE_WIDTH)));
      S_RD10:  rd_addr_s = AW'(linear_addr(32'(row1_q), 32'(col_q),  32'(IMAGE_WIDTH)));
      S_RD11:  rd_addr_s = AW'(linear_addr(32'(row1_q), 32'(col1_q), 32'(IMAGE_WIDTH)));
      default: rd_addr_s = '0;
    endcase
  end

  // Neighbour capture: RAM data arrives one state after its address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p00_q <= '0;
      p01_q <= '0;
      p10_q <= '0;
      p11_q <= '0;
    end else begin
      case (state_q)
        S_RD01:  p00_q <= rd_data_s;
        S_RD10:  p01_q <= rd_data_s;
        S_RD11:  p10_q <= rd_data_s;
        S_WAIT:  p11_q <= rd_data_s;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------- interpolator
  // Rounded bilinear blend; the final shift keeps bits 25:16, saturated.
  always_comb begin
    wx0_s    = 9'd256 - {1'b0, fx_q};
    wy0_s    = 9'd256 - {1'b0, fy_q};
    top_s    = 17'(p00_q) * 17'(wx0_s) + 17'(p01_q) * 17'(fx_q);
    bot_s    = 17'(p10_q) * 17'(wx0_s) + 17'(p11_q) * 17'(fx_q);
    acc_s    = 26'(top_s) * 26'(wy0_s) + 26'(bot_s) * 26'(fy_q);
    rnd_s    = acc_s + 26'd32768;
    shr_s    = 10'(rnd_s >> 16);
    interp_s = (shr_s > 10'd255) ? 8'd255 : shr_s[7:0];
  end

  // ----------------------------------------------------------------- FSM
  // Next state and registered-output next values.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    out_pixel_d = out_pixel_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_RD00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD00:  state_d = S_RD01;
      S_RD01:  state_d = S_RD10;
      S_RD10:  state_d = S_RD11;
      S_RD11:  state_d = S_WAIT;
      S_WAIT:  state_d = S_CALC;
      S_CALC: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        if (oob_q) begin
          out_pixel_d = '0;
        end else begin
          out_pixel_d = interp_s;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so that ready stays low during reset and rises on the
    // first clock after release.
    map_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      map_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      map_ready_q <= map_ready_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  assign map_ready = map_ready_q;
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_remap.sv
module tb_remap;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        map_valid;
  logic [23:0] map_x;
  logic [23:0] map_y;
  logic        map_ready;
  logic        out_valid;
  logic [7:0]  out_pixel;

  int checks = 0;
  int errors = 0;

  remap dut (
    .clk         (clk),
    .rst         (rst),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .map_valid   (map_valid),
    .map_x       (map_x),
    .map_y       (map_y),
    .map_ready   (map_ready),
    .out_valid   (out_valid),
    .out_pixel   (out_pixel)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; performs one write on the next rising edge.
  task automatic wr(input int addr, input int data);
    mem_wr_en   = 1'b1;
    mem_wr_addr = 32'(addr);
    mem_wr_data = 8'(data);
    @(negedge clk);
    mem_wr_en   = 1'b0;
  endtask

  // Loads pixel[i] = i % 256 for the 2x2 neighbourhood of (row, col).
  task automatic preload(input int row, input int col);
    for (int r = row; r <= row + 1 && r < 480; r++)
      for (int c = col; c <= col + 1 && c < 640; c++)
        wr(r * 640 + c, (r * 640 + c) % 256);
  endtask

  // Called at a negedge. lat = number of negedges after the accepting edge
  // at which out_valid is first seen (20 on timeout).
  task automatic request(input logic [23:0] x, input logic [23:0] y,
                         output logic [7:0] pix, output int lat);
    int n;
    n = 0;
    while (!map_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    map_x     = x;
    map_y     = y;
    map_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    map_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    pix = out_pixel;
  endtask

  typedef struct {
    string       name;
    logic [23:0] x;
    logic [23:0] y;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [7:0] pix;
    logic [7:0] held;
    int         lat;
    int         pulses;
    int         first;
    int         hold_ok;

    vecs[0]  = '{"int_0_0",     24'(0),              24'(0),              8'd0};
    vecs[1]  = '{"int_159_119", 24'(159 * 4096),     24'(119 * 4096),     8'd31};
    vecs[2]  = '{"int_319_239", 24'(319 * 4096),     24'(239 * 4096),     8'd191};
    vecs[3]  = '{"int_479_359", 24'(479 * 4096),     24'(359 * 4096),     8'd95};
    vecs[4]  = '{"int_639_479", 24'(639 * 4096),     24'(479 * 4096),     8'd255};
    vecs[5]  = '{"bil_x10h",    24'(10 * 4096 + 2048), 24'(10 * 4096),    8'd100};
    vecs[6]  = '{"bil_xy10h",   24'(10 * 4096 + 2048), 24'(10 * 4096 + 2048), 8'd100};
    vecs[7]  = '{"bil_x10q",    24'(10 * 4096 + 1024), 24'(10 * 4096),    8'd50};
    vecs[8]  = '{"oob_xneg",    24'hFFF000,          24'(5 * 4096),       8'd0};
    vecs[9]  = '{"clamp_edge",  24'(639 * 4096 + 2048), 24'(479 * 4096 + 2048), 8'd255};
    vecs[10] = '{"oob_x640",    24'(640 * 4096),     24'(5 * 4096),       8'd0};
    vecs[11] = '{"int_159_119b",24'(159 * 4096),     24'(119 * 4096),     8'd31};
    vecs[12] = '{"oob_y480",    24'(0),              24'(480 * 4096),     8'd0};

    rst = 1'b1; mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
    map_valid = 1'b0; map_x = '0; map_y = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_map_ready", int'(map_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(map_ready), 1);

    // Frame preload around every coordinate that is read
    preload(0, 0);
    preload(119, 159);
    preload(239, 319);
    preload(359, 479);
    preload(478, 638);
    preload(5, 0);
    wr(10 * 640 + 10, 0);
    wr(10 * 640 + 11, 200);
    wr(11 * 640 + 10, 0);
    wr(11 * 640 + 11, 200);

    // Table-driven requests
    for (int i = 0; i < 13; i++) begin
      request(vecs[i].x, vecs[i].y, pix, lat);
      chk({vecs[i].name, "_pix"}, int'(pix), int'(vecs[i].exp));
      chk({vecs[i].name, "_lat"}, lat, 7);
    end

    // Busy pulse must be dropped; out_pixel must hold afterwards
    @(negedge clk);
    map_x = 24'(319 * 4096); map_y = 24'(239 * 4096); map_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    map_valid = 1'b0;
    pulses = 0; first = 0; hold_ok = 1; held = 8'd0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin
        map_x = 24'(0); map_y = 24'(0); map_valid = 1'b1;
      end
      if (k == 4) map_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (first == 0) begin
          first = k;
          held = out_pixel;
        end
      end else if (first != 0 && k <= first + 10 && out_pixel != held) begin
        hold_ok = 0;
      end
      @(negedge clk);
    end
    chk("busy_pulses", pulses, 1);
    chk("busy_lat", first, 7);
    chk("busy_pix", int'(held), 191);
    chk("hold_10", hold_ok, 1);

    // Reset in the middle of a request
    map_x = 24'(479 * 4096); map_y = 24'(359 * 4096); map_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    map_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", int'(map_ready), 0);
    chk("midrst_valid", int'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", int'(map_ready), 1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    chk("midrst_no_valid", pulses, 0);
    request(24'(479 * 4096), 24'(359 * 4096), pix, lat);
    chk("midrst_next_pix", int'(pix), 95);
    chk("midrst_next_lat", lat, 7);

    // Write to the address being read: read-first returns old data
    map_x = 24'(159 * 4096); map_y = 24'(119 * 4096); map_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    map_valid   = 1'b0;
    mem_wr_en   = 1'b1;
    mem_wr_addr = 32'(119 * 640 + 159);
    mem_wr_data = 8'd77;
    @(negedge clk);
    mem_wr_en = 1'b0;
    lat = 2;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rdfirst_pix", int'(out_pixel), 31);
    chk("rdfirst_lat", lat, 7);
    request(24'(159 * 4096), 24'(119 * 4096), pix, lat);
    chk("rdfirst_new_pix", int'(pix), 77);

    // Out-of-range writes are ignored (including one that aliases on truncation)
    wr(307200, 9);
    wr(32'h0008_0000, 9);
    request(24'(0), 24'(0), pix, lat);
    chk("oob_write_pix", int'(pix), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
